// File: rtl/rr_pkg.sv
// Shared encodings for the per-slave round-robin ack router.
// Status codes, command codes, FSM states and a one-hot helper.
package rr_pkg;

    localparam logic [1:0] NO_REQ = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] W_ACK  = 2'd2;
    localparam logic [1:0] W_DATA = 2'd3;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [15:0] onehot16(input logic [3:0] id);
        onehot16 = 16'd1 << id;
    endfunction

endpackage

// File: rtl/rr_id_fifo.sv
// Small FIFO of master ids; steers late read data to the issuing master.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module rr_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd];
    assign o_count   = r_cnt;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + (AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_cnt <= r_cnt - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rr_ack_router.sv
// Per-slave round-robin arbiter: grants one master, routes the slave ack
// back to it and remembers read issuers so returned data finds its owner.
module rr_ack_router
    import rr_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int SLAVE_IDW = 1,
    parameter int SLAVE_NO  = 0,
    parameter int RD_DEPTH  = 4,
    localparam int MW       = $clog2(N_MASTERS),
    localparam int CW       = $clog2(RD_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2*N_MASTERS-1:0]         req_stat,
    input  logic [N_MASTERS*SLAVE_IDW-1:0] sfor,
    input  logic [N_MASTERS-1:0]           req_cmd,
    input  logic                           ack_in,
    input  logic                           rdata_vld,
    output logic [N_MASTERS-1:0]           ack,
    output logic                           gnt_vld,
    output logic [MW-1:0]                  gnt_id,
    output logic [MW-1:0]                  last_mas,
    output logic [N_MASTERS-1:0]           rdata_dst,
    output logic [CW-1:0]                  rd_cnt,
    output logic                           rd_full,
    output logic                           err
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MW-1:0]        r_gnt_id;
    logic [MW-1:0]        w_gnt_nxt;
    logic [MW-1:0]        r_last_mas;
    logic [MW-1:0]        w_last_nxt;
    logic [MW-1:0]        w_sel;
    logic [MW-1:0]        w_idx;
    logic                 w_found;
    logic [N_MASTERS-1:0] w_elig;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [MW-1:0]        w_head;
    logic                 r_err;

    // Reads are held back while the return queue is full; writes never are.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_elig[i] = (req_stat[2*i +: 2] == W_ACK)
                     && (sfor[i*SLAVE_IDW +: SLAVE_IDW] == SLAVE_IDW'(SLAVE_NO))
                     && !((req_cmd[i] == CMD_RD) && rd_full);
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            w_idx = MW'((int'(r_last_mas) + k) % N_MASTERS);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_last_nxt  = r_last_mas;
        w_push      = 1'b0;
        ack         = '0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_sel;
                end
            end
            GRANT: begin
                if (ack_in) begin
                    ack         = N_MASTERS'(onehot16(4'(r_gnt_id)));
                    w_last_nxt  = r_gnt_id;
                    w_push      = (req_cmd[r_gnt_id] == CMD_RD);
                    w_state_nxt = IDLE;
                end else if (!w_elig[r_gnt_id]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_gnt_id   <= '0;
            r_last_mas <= MW'(N_MASTERS - 1);
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_id   <= w_gnt_nxt;
            r_last_mas <= w_last_nxt;
            r_err      <= r_err
                       || (ack_in && (r_state != GRANT))
                       || (rdata_vld && w_empty);
        end
    end

    rr_id_fifo #(
        .W     (MW),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (r_gnt_id),
        .i_pop   (rdata_vld),
        .o_head  (w_head),
        .o_count (rd_cnt),
        .o_full  (rd_full),
        .o_empty (w_empty)
    );

    assign w_pop     = rdata_vld && !w_empty;
    assign rdata_dst = w_pop ? N_MASTERS'(onehot16(4'(w_head))) : '0;
    assign gnt_vld   = (r_state == GRANT);
    assign gnt_id    = r_gnt_id;
    assign last_mas  = r_last_mas;
    assign err       = r_err;

endmodule

// File: tb/tb_rr_ack_router.sv
// Scenario bench for rr_ack_router: expected acks and read destinations
// are queued when requests are posted and consumed as the DUT responds.
module tb_rr_ack_router;
    import rr_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req_stat;
    logic [3:0] sfor;
    logic [3:0] req_cmd;
    logic       ack_in;
    logic       rdata_vld;
    logic [3:0] ack;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic [1:0] last_mas;
    logic [3:0] rdata_dst;
    logic [2:0] rd_cnt;
    logic       rd_full;
    logic       err;

    int errors = 0;
    int checks = 0;
    int exp_ack[$];
    int exp_rd[$];
    bit auto_ack = 1'b0;

    always #5 clk = ~clk;

    rr_ack_router #(
        .N_MASTERS (4),
        .SLAVE_IDW (1),
        .SLAVE_NO  (0),
        .RD_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_stat  (req_stat),
        .sfor      (sfor),
        .req_cmd   (req_cmd),
        .ack_in    (ack_in),
        .rdata_vld (rdata_vld),
        .ack       (ack),
        .gnt_vld   (gnt_vld),
        .gnt_id    (gnt_id),
        .last_mas  (last_mas),
        .rdata_dst (rdata_dst),
        .rd_cnt    (rd_cnt),
        .rd_full   (rd_full),
        .err       (err)
    );

    // Slave model: accept whenever a grant is held (drives ack_in only).
    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_ack) ack_in = gnt_vld;
        #2;
    endtask

    task automatic set_m(input int i, input logic [1:0] st,
                         input logic sf, input logic cmd);
        req_stat[2*i +: 2] = st;
        sfor[i]            = sf;
        req_cmd[i]         = cmd;
    endtask

    task automatic clear_all();
        req_stat  = '0;
        sfor      = '0;
        req_cmd   = '1;
        ack_in    = 1'b0;
        rdata_vld = 1'b0;
        auto_ack  = 1'b0;
        exp_ack.delete();
        exp_rd.delete();
    endtask

    task automatic do_reset();
        clear_all();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL rst_gnt_vld got %b want 0", gnt_vld); end
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL rst_gnt_id got %0d want 0", gnt_id); end
        checks++; if (last_mas !== 2'd3) begin errors++; $display("FAIL rst_last_mas got %0d want 3", last_mas); end
        checks++; if (rd_cnt !== 3'd0) begin errors++; $display("FAIL rst_rd_cnt got %0d want 0", rd_cnt); end
        checks++; if (rd_full !== 1'b0) begin errors++; $display("FAIL rst_rd_full got %b want 0", rd_full); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        checks++; if (ack !== 4'd0) begin errors++; $display("FAIL rst_ack got %b want 0000", ack); end
        checks++; if (rdata_dst !== 4'd0) begin errors++; $display("FAIL rst_rdata_dst got %b want 0000", rdata_dst); end
    endtask

    task automatic test_fairness();
        int c = 0;
        int last_c = -1;
        int prev = 3;
        int e;
        do_reset();
        for (int i = 0; i < 4; i++) set_m(i, W_ACK, 1'b0, CMD_WR);
        for (int r = 0; r < 8; r++) exp_ack.push_back(r % 4);
        auto_ack = 1'b1;
        while (exp_ack.size() > 0 && c < 40) begin
            cyc();
            c++;
            if (ack !== 4'd0) begin
                e = exp_ack.pop_front();
                checks++;
                if (ack !== 4'(1 << e)) begin errors++; $display("FAIL fair_ack got %b want %b", ack, 4'(1 << e)); end
                checks++;
                if (last_mas !== 2'(prev)) begin errors++; $display("FAIL fair_last_mas got %0d want %0d", last_mas, prev); end
                if (last_c >= 0) begin
                    checks++;
                    if (c - last_c != 2) begin errors++; $display("FAIL fair_gap got %0d want 2", c - last_c); end
                end
                prev   = e;
                last_c = c;
            end
        end
        checks++; if (exp_ack.size() != 0) begin errors++; $display("FAIL fair_timeout left %0d want 0", exp_ack.size()); end
        cyc();
        auto_ack = 1'b0;
        ack_in   = 1'b0;
        checks++; if (last_mas !== 2'd3) begin errors++; $display("FAIL fair_last_end got %0d want 3", last_mas); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fair_err got %b want 0", err); end
    endtask

    task automatic test_filter();
        int c = 0;
        int e;
        do_reset();
        set_m(1, W_ACK, 1'b1, CMD_WR);
        set_m(3, W_ACK, 1'b1, CMD_WR);
        set_m(2, W_ACK, 1'b0, CMD_WR);
        for (int r = 0; r < 3; r++) exp_ack.push_back(2);
        auto_ack = 1'b1;
        while (exp_ack.size() > 0 && c < 30) begin
            cyc();
            c++;
            if (ack !== 4'd0) begin
                e = exp_ack.pop_front();
                checks++;
                if (ack !== 4'(1 << e)) begin errors++; $display("FAIL filter_ack got %b want %b", ack, 4'(1 << e)); end
            end
        end
        checks++; if (exp_ack.size() != 0) begin errors++; $display("FAIL filter_timeout left %0d want 0", exp_ack.size()); end
        cyc();
        auto_ack = 1'b0;
        ack_in   = 1'b0;
    endtask

    task automatic test_read_routing();
        int c = 0;
        int e;
        do_reset();
        set_m(2, W_ACK, 1'b0, CMD_RD);
        exp_ack.push_back(2); exp_ack.push_back(0);
        exp_rd.push_back(2);  exp_rd.push_back(0);
        auto_ack = 1'b1;
        while (exp_ack.size() > 0 && c < 40) begin
            cyc();
            c++;
            if (ack !== 4'd0) begin
                e = exp_ack.pop_front();
                checks++;
                if (ack !== 4'(1 << e)) begin errors++; $display("FAIL rd_ack got %b want %b", ack, 4'(1 << e)); end
                set_m(e, NO_REQ, 1'b0, CMD_RD);
                if (e == 2) set_m(0, W_ACK, 1'b0, CMD_RD);
            end
        end
        checks++; if (exp_ack.size() != 0) begin errors++; $display("FAIL rd_timeout left %0d want 0", exp_ack.size()); end
        cyc();
        auto_ack = 1'b0;
        ack_in   = 1'b0;
        checks++; if (rd_cnt !== 3'd2) begin errors++; $display("FAIL rd_cnt2 got %0d want 2", rd_cnt); end
        for (int k = 0; k < 2; k++) begin
            rdata_vld = 1'b1;
            #1;
            e = exp_rd.pop_front();
            checks++;
            if (rdata_dst !== 4'(1 << e)) begin errors++; $display("FAIL rd_dst got %b want %b", rdata_dst, 4'(1 << e)); end
            cyc();
        end
        rdata_vld = 1'b0;
        #1;
        checks++; if (rdata_dst !== 4'd0) begin errors++; $display("FAIL rd_dst_idle got %b want 0000", rdata_dst); end
        checks++; if (rd_cnt !== 3'd0) begin errors++; $display("FAIL rd_cnt0 got %0d want 0", rd_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", err); end
    endtask

    task automatic test_full_gating();
        int c = 0;
        int e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_m(i, W_ACK, 1'b0, CMD_RD);
            exp_ack.push_back(i);
            exp_rd.push_back(i);
        end
        auto_ack = 1'b1;
        while (exp_ack.size() > 0 && c < 40) begin
            cyc();
            c++;
            if (ack !== 4'd0) begin
                e = exp_ack.pop_front();
                checks++;
                if (ack !== 4'(1 << e)) begin errors++; $display("FAIL full_fill_ack got %b want %b", ack, 4'(1 << e)); end
                set_m(e, NO_REQ, 1'b0, CMD_RD);
            end
        end
        checks++; if (exp_ack.size() != 0) begin errors++; $display("FAIL full_fill_timeout left %0d want 0", exp_ack.size()); end
        cyc();
        checks++; if (rd_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", rd_full); end
        checks++; if (rd_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d want 4", rd_cnt); end
        set_m(1, W_ACK, 1'b0, CMD_RD);
        set_m(3, W_ACK, 1'b0, CMD_WR);
        exp_ack.push_back(3);
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (ack !== 4'd0) begin
                checks++;
                if (exp_ack.size() == 0) begin
                    errors++; $display("FAIL full_blocked_ack got %b want 0000", ack);
                end else begin
                    e = exp_ack.pop_front();
                    if (ack !== 4'(1 << e)) begin errors++; $display("FAIL full_wr_ack got %b want %b", ack, 4'(1 << e)); end
                    set_m(e, NO_REQ, 1'b0, CMD_WR);
                end
            end
        end
        checks++; if (exp_ack.size() != 0) begin errors++; $display("FAIL full_wr_timeout left %0d want 0", exp_ack.size()); end
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL full_no_grant got %b want 0", gnt_vld); end
        rdata_vld = 1'b1;
        #1;
        e = exp_rd.pop_front();
        checks++; if (rdata_dst !== 4'(1 << e)) begin errors++; $display("FAIL full_dst got %b want %b", rdata_dst, 4'(1 << e)); end
        cyc();
        rdata_vld = 1'b0;
        exp_ack.push_back(1);
        exp_rd.push_back(1);
        c = 0;
        while (exp_ack.size() > 0 && c < 10) begin
            cyc();
            c++;
            if (ack !== 4'd0) begin
                e = exp_ack.pop_front();
                checks++;
                if (ack !== 4'(1 << e)) begin errors++; $display("FAIL full_rd_ack got %b want %b", ack, 4'(1 << e)); end
                set_m(e, NO_REQ, 1'b0, CMD_RD);
            end
        end
        checks++; if (exp_ack.size() != 0) begin errors++; $display("FAIL full_rd_timeout left %0d want 0", exp_ack.size()); end
        cyc();
        auto_ack = 1'b0;
        ack_in   = 1'b0;
        checks++; if (rd_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt_end got %0d want 4", rd_cnt); end
    endtask

    task automatic test_withdraw_err();
        do_reset();
        set_m(2, W_ACK, 1'b0, CMD_WR);
        cyc();
        checks++; if (gnt_vld !== 1'b1) begin errors++; $display("FAIL wd_gnt got %b want 1", gnt_vld); end
        checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL wd_gnt_id got %0d want 2", gnt_id); end
        set_m(2, NO_REQ, 1'b0, CMD_WR);
        cyc();
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL wd_drop got %b want 0", gnt_vld); end
        checks++; if (last_mas !== 2'd3) begin errors++; $display("FAIL wd_last_mas got %0d want 3", last_mas); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_err0 got %b want 0", err); end
        ack_in = 1'b1;
        #1;
        checks++; if (ack !== 4'd0) begin errors++; $display("FAIL wd_idle_ack got %b want 0000", ack); end
        cyc();
        ack_in = 1'b0;
        cyc();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err_ack got %b want 1", err); end
        cyc();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err_sticky got %b want 1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_err_clr got %b want 0", err); end
        rdata_vld = 1'b1;
        #1;
        checks++; if (rdata_dst !== 4'd0) begin errors++; $display("FAIL wd_empty_dst got %b want 0000", rdata_dst); end
        cyc();
        rdata_vld = 1'b0;
        cyc();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err_empty got %b want 1", err); end
        checks++; if (rd_cnt !== 3'd0) begin errors++; $display("FAIL wd_cnt got %0d want 0", rd_cnt); end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        int e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_m(i, W_ACK, 1'b0, CMD_RD);
            exp_ack.push_back(i);
        end
        auto_ack = 1'b1;
        while (exp_ack.size() > 0 && c < 30) begin
            cyc();
            c++;
            if (ack !== 4'd0) begin
                e = exp_ack.pop_front();
                checks++;
                if (ack !== 4'(1 << e)) begin errors++; $display("FAIL mid_ack got %b want %b", ack, 4'(1 << e)); end
                set_m(e, NO_REQ, 1'b0, CMD_RD);
            end
        end
        checks++; if (exp_ack.size() != 0) begin errors++; $display("FAIL mid_timeout left %0d want 0", exp_ack.size()); end
        cyc();
        auto_ack = 1'b0;
        ack_in   = 1'b0;
        checks++; if (rd_cnt !== 3'd3) begin errors++; $display("FAIL mid_cnt3 got %0d want 3", rd_cnt); end
        set_m(3, W_ACK, 1'b0, CMD_WR);
        cyc();
        checks++; if (gnt_vld !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b want 1", gnt_vld); end
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL mid_gnt_clr got %b want 0", gnt_vld); end
        checks++; if (rd_cnt !== 3'd0) begin errors++; $display("FAIL mid_cnt_clr got %0d want 0", rd_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err); end
        checks++; if (last_mas !== 2'd3) begin errors++; $display("FAIL mid_last_mas got %0d want 3", last_mas); end
        checks++; if (ack !== 4'd0) begin errors++; $display("FAIL mid_ack_clr got %b want 0000", ack); end
        for (int i = 0; i < 4; i++) set_m(i, W_ACK, 1'b0, CMD_WR);
        exp_ack.push_back(0);
        auto_ack = 1'b1;
        c = 0;
        while (exp_ack.size() > 0 && c < 10) begin
            cyc();
            c++;
            if (ack !== 4'd0) begin
                e = exp_ack.pop_front();
                checks++;
                if (ack !== 4'(1 << e)) begin errors++; $display("FAIL mid_first got %b want %b", ack, 4'(1 << e)); end
            end
        end
        checks++; if (exp_ack.size() != 0) begin errors++; $display("FAIL mid_first_timeout left %0d want 0", exp_ack.size()); end
        cyc();
        auto_ack = 1'b0;
        ack_in   = 1'b0;
    endtask

    initial begin
        clear_all();
        reset = 1'b0;
        test_reset();
        test_fairness();
        test_filter();
        test_read_routing();
        test_full_gating();
        test_withdraw_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
